// File: rtl/ec_arb_pkg.sv
// Shared types and helpers for the ec/comm send-channel arbiter.
package ec_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [7:0] HDR_TAG_DEFAULT = 8'hEC;

  // Header word layout: tag in the top byte, source id, then sequence number.
  function automatic logic [31:0] pack_hdr(input logic [7:0]  tag,
                                           input logic [7:0]  id,
                                           input logic [15:0] seq);
    return {tag, id, seq};
  endfunction

endpackage

// File: rtl/ec_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module ec_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  index
);

  logic [NREQ-1:0] hi_s;
  logic [IDW-1:0]  hi_idx_s;
  logic [IDW-1:0]  lo_idx_s;

  // Lowest request in the upper window wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_s     = '0;
    hi_idx_s = '0;
    lo_idx_s = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      hi_s[i]  = req[i] && (IDW'(i) >= ptr);
      hi_idx_s = hi_s[i] ? IDW'(i) : hi_idx_s;
      lo_idx_s = req[i]  ? IDW'(i) : lo_idx_s;
    end
    found = |req;
    index = (|hi_s) ? hi_idx_s : lo_idx_s;
  end

endmodule

// File: rtl/ec_send_arb.sv
// Round-robin arbiter sharing the 32-bit ec/comm send channel between NREQ requesters,
// granting whole bursts with an optional header word and MAX_BURST / STALL_MAX limits.
module ec_send_arb
  import ec_arb_pkg::*;
#(
  parameter int         NREQ      = 4,
  parameter int         IDW       = 2,
  parameter bit         HDR_EN    = 1'b1,
  parameter logic [7:0] HDR_TAG   = HDR_TAG_DEFAULT,
  parameter int         MAX_BURST = 64,
  parameter int         STALL_MAX = 255
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [32*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ack,
  output logic               valid_o,
  output logic [31:0]        data_o,
  input  logic               ack_o,
  output logic [IDW-1:0]     grant_id,
  output logic               busy,
  output logic               trunc_o,
  output logic               abort_o
);

  localparam int             WCW       = $clog2(MAX_BURST + 1);
  localparam int             SCW       = $clog2(STALL_MAX + 1);
  localparam logic [WCW-1:0] WCNT_LIM  = WCW'(MAX_BURST);
  localparam logic [SCW-1:0] STALL_LIM = SCW'(STALL_MAX);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NREQ - 1);

  arb_state_e     state_r;
  arb_state_e     state_nxt_s;
  logic [IDW-1:0] grant_r;
  logic [IDW-1:0] rr_ptr_r;
  logic [15:0]    seq_r;
  logic [WCW-1:0] wcnt_r;
  logic [SCW-1:0] stall_r;
  logic           trunc_r;
  logic           abort_r;

  logic           pick_found_s;
  logic [IDW-1:0] pick_idx_s;
  logic           gvalid_s;
  logic           glast_s;
  logic [31:0]    gdata_s;
  logic           xfer_s;
  logic           data_exit_s;
  logic           trunc_nxt_s;
  logic           abort_nxt_s;
  logic [WCW-1:0] wcnt_inc_s;
  logic [SCW-1:0] stall_inc_s;

  ec_rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .found (pick_found_s),
    .index (pick_idx_s)
  );

  // Granted requester's lane.
  always_comb begin
    gvalid_s = req_valid[grant_r];
    glast_s  = req_last[grant_r];
    gdata_s  = req_data[32*int'(grant_r) +: 32];
  end

  // Link-side outputs; data is forced to zero whenever nothing is offered.
  always_comb begin
    valid_o = 1'b0;
    data_o  = 32'h0;
    req_ack = '0;
    case (state_r)
      ST_HDR: begin
        valid_o = 1'b1;
        data_o  = pack_hdr(HDR_TAG, 8'(grant_r), seq_r);
      end
      ST_DATA: begin
        valid_o          = gvalid_s;
        data_o           = gvalid_s ? gdata_s : 32'h0;
        req_ack[grant_r] = gvalid_s && ack_o;
      end
      default: begin
        valid_o = 1'b0;
        data_o  = 32'h0;
        req_ack = '0;
      end
    endcase
  end

  assign xfer_s = valid_o && ack_o;

  // Next state and burst termination (last wins over the MAX_BURST cut).
  always_comb begin
    state_nxt_s = state_r;
    data_exit_s = 1'b0;
    trunc_nxt_s = 1'b0;
    abort_nxt_s = 1'b0;
    wcnt_inc_s  = wcnt_r + WCW'(1);
    stall_inc_s = stall_r + SCW'(1);
    case (state_r)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_nxt_s = HDR_EN ? ST_HDR : ST_DATA;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        state_nxt_s = xfer_s ? ST_DATA : ST_HDR;
      end
      ST_DATA: begin
        if (xfer_s) begin
          if (glast_s) begin
            data_exit_s = 1'b1;
          end else if (wcnt_inc_s == WCNT_LIM) begin
            data_exit_s = 1'b1;
            trunc_nxt_s = 1'b1;
          end else begin
            data_exit_s = 1'b0;
          end
        end else if (!gvalid_s && (stall_inc_s == STALL_LIM)) begin
          data_exit_s = 1'b1;
          abort_nxt_s = 1'b1;
        end else begin
          data_exit_s = 1'b0;
        end
        state_nxt_s = data_exit_s ? ST_IDLE : ST_DATA;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, grant, counters and pulse registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_r  <= ST_IDLE;
      grant_r  <= '0;
      rr_ptr_r <= '0;
      seq_r    <= 16'h0;
      wcnt_r   <= '0;
      stall_r  <= '0;
      trunc_r  <= 1'b0;
      abort_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      trunc_r <= trunc_nxt_s;
      abort_r <= abort_nxt_s;
      case (state_r)
        ST_IDLE: begin
          wcnt_r  <= '0;
          stall_r <= '0;
          if (pick_found_s) begin
            grant_r <= pick_idx_s;
          end
        end
        ST_HDR: begin
          if (xfer_s) begin
            seq_r <= seq_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (xfer_s) begin
            wcnt_r <= wcnt_inc_s;
          end
          stall_r <= gvalid_s ? '0 : stall_inc_s;
          // Owner drops to lowest priority on any exit so others get a turn.
          if (data_exit_s) begin
            rr_ptr_r <= (grant_r == LAST_ID) ? '0 : grant_r + IDW'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_r != ST_IDLE);
  assign grant_id = grant_r;
  assign trunc_o  = trunc_r;
  assign abort_o  = abort_r;

endmodule

// File: tb/tb_ec_send_arb.sv
// Self-checking bench for ec_send_arb: requester models feed a link-side scoreboard.
module tb_ec_send_arb;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct {
    logic [31:0] d;
    logic        last;
    int          gap;
  } word_t;

  typedef struct {
    int src;
    int n;
    bit tog;
    int exp_grant;
    int exp_acks;
  } vec_t;

  logic               CLK = 1'b0;
  logic               RST;
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ack;
  logic               valid_o;
  logic [31:0]        data_o;
  logic               ack_o;
  logic [IDW-1:0]     grant_id;
  logic               busy;
  logic               trunc_o;
  logic               abort_o;

  always #5 CLK = ~CLK;

  ec_send_arb #(
    .NREQ      (NREQ),
    .IDW       (IDW),
    .HDR_EN    (1'b1),
    .HDR_TAG   (8'hEC),
    .MAX_BURST (4),
    .STALL_MAX (8)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ack   (req_ack),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .ack_o     (ack_o),
    .grant_id  (grant_id),
    .busy      (busy),
    .trunc_o   (trunc_o),
    .abort_o   (abort_o)
  );

  word_t       src_q[NREQ][$];
  int          hold[NREQ];
  logic [31:0] exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          exp_seq = 0;
  int          ack_cnt[NREQ];
  int          trunc_cnt = 0;
  int          abort_cnt = 0;
  int          stall_run = 0;
  int          idle_run = 0;
  int          gr_seen = 0;
  bit          chk_gap = 1'b0;
  bit          seen_end = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int k, input int i);
    return {8'hD0, 8'(k), 16'(i)};
  endfunction

  task automatic src_push(input int k, input logic [31:0] d, input logic last, input int gap);
    word_t w;
    w.d    = d;
    w.last = last;
    w.gap  = gap;
    src_q[k].push_back(w);
  endtask

  task automatic push_hdr(input int id);
    exp_q.push_back({8'hEC, 8'(id), 16'(exp_seq)});
    exp_seq++;
  endtask

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  function automatic bit srcs_empty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      if (src_q[k].size() != 0) e = 1'b0;
    end
    return e;
  endfunction

  task automatic wait_done(input bit tog, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !busy && srcs_empty()) && n < budget) begin
      ack_o = tog ? ~ack_o : 1'b1;
      tick();
      n++;
    end
    check("done_in_budget", 32'(n < budget), 32'd1);
    ack_o = 1'b1;
  endtask

  // Requester models plus link monitor: sample at negedge, update sources after posedge.
  initial begin
    logic [NREQ-1:0] ack_snap;
    logic [31:0]     e;
    bit              prev_busy;
    bit              prev_pend;
    logic [31:0]     prev_d;
    prev_busy = 1'b0;
    prev_pend = 1'b0;
    prev_d    = 32'h0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    for (int k = 0; k < NREQ; k++) begin
      hold[k]    = 0;
      ack_cnt[k] = 0;
    end
    forever begin
      @(negedge CLK);
      ack_snap = RST ? req_ack : '0;
      if (RST) begin
        if (valid_o && ack_o) begin
          if (exp_q.size() == 0) begin
            check("sb_nonempty", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            check("link_word", data_o, e);
          end
        end
        if (!valid_o) check("data_zero_idle", data_o, 32'h0);
        if (prev_pend) begin
          check("hold_valid", 32'(valid_o), 32'd1);
          check("hold_data", data_o, prev_d);
        end
        prev_pend = valid_o && !ack_o;
        prev_d    = data_o;
        for (int k = 0; k < NREQ; k++) ack_cnt[k] += int'(req_ack[k]);
        if (trunc_o) begin
          trunc_cnt++;
          check("trunc_idle", 32'(busy), 32'd0);
        end
        if (abort_o) begin
          abort_cnt++;
          check("abort_idle", 32'(busy), 32'd0);
          check("stall_len", 32'(stall_run), 32'd8);
        end
        if (busy && !valid_o) stall_run++;
        else if (valid_o) stall_run = 0;
        if (busy) begin
          if (!prev_busy && chk_gap && seen_end) check("idle_gap", 32'(idle_run), 32'd1);
          idle_run = 0;
          gr_seen  = int'(grant_id);
        end else begin
          idle_run++;
          if (prev_busy) seen_end = 1'b1;
        end
        prev_busy = busy;
      end else begin
        prev_pend = 1'b0;
        prev_busy = 1'b0;
      end
      @(posedge CLK);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (ack_snap[k] && src_q[k].size() > 0) begin
          hold[k] = src_q[k][0].gap;
          src_q[k].delete(0);
        end else if (hold[k] > 0) begin
          hold[k]--;
        end
        req_valid[k]         = (src_q[k].size() > 0) && (hold[k] == 0);
        req_data[32*k +: 32] = (src_q[k].size() > 0) ? src_q[k][0].d : 32'h0;
        req_last[k]          = (src_q[k].size() > 0) && src_q[k][0].last;
      end
    end
  end

  initial begin
    vec_t tbl[5];
    int   tb_base;
    int   ab_base;
    int   a_base[NREQ];
    int   n;

    tbl[0] = '{src: 1, n: 3, tog: 1'b0, exp_grant: 1, exp_acks: 3};
    tbl[1] = '{src: 3, n: 2, tog: 1'b1, exp_grant: 3, exp_acks: 2};
    tbl[2] = '{src: 0, n: 4, tog: 1'b0, exp_grant: 0, exp_acks: 4};
    tbl[3] = '{src: 2, n: 3, tog: 1'b1, exp_grant: 2, exp_acks: 3};
    tbl[4] = '{src: 1, n: 1, tog: 1'b0, exp_grant: 1, exp_acks: 1};

    RST   = 1'b0;
    ack_o = 1'b0;
    repeat (3) tick();
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(req_ack), 32'd0);
    check("rst_data", data_o, 32'h0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_trunc", 32'(trunc_o), 32'd0);
    check("rst_abort", 32'(abort_o), 32'd0);
    RST   = 1'b1;
    ack_o = 1'b1;
    tick();

    // All requesters valid, 1-word bursts: grants rotate 0..3 twice, seq 0..7.
    chk_gap  = 1'b1;
    seen_end = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) src_push(k, wd(k, r), 1'b1, 0);
    end
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NREQ; k++) begin
        push_hdr(k);
        exp_q.push_back(wd(k, r));
      end
    end
    wait_done(1'b0, 200);
    chk_gap = 1'b0;

    // Single-requester bursts, with and without ack toggling.
    for (int e = 0; e < 5; e++) begin
      tb_base = trunc_cnt;
      a_base[0] = ack_cnt[tbl[e].src];
      for (int i = 0; i < tbl[e].n; i++) begin
        src_push(tbl[e].src, wd(tbl[e].src, 16'h0040 + e * 8 + i), 1'(i == tbl[e].n - 1), 0);
      end
      push_hdr(tbl[e].src);
      for (int i = 0; i < tbl[e].n; i++) exp_q.push_back(wd(tbl[e].src, 16'h0040 + e * 8 + i));
      wait_done(tbl[e].tog, 200);
      check("tbl_grant", 32'(gr_seen), 32'(tbl[e].exp_grant));
      check("tbl_acks", 32'(ack_cnt[tbl[e].src] - a_base[0]), 32'(tbl[e].exp_acks));
      check("tbl_no_trunc", 32'(trunc_cnt - tb_base), 32'd0);
    end

    // Requester 2 runs past MAX_BURST=4; requester 0 gets the next grant.
    tb_base = trunc_cnt;
    ab_base = abort_cnt;
    for (int k = 0; k < NREQ; k++) a_base[k] = ack_cnt[k];
    for (int i = 0; i < 6; i++) src_push(2, wd(2, 16'h0100 + i), 1'(i == 5), 0);
    src_push(0, wd(0, 16'h0200), 1'b1, 0);
    push_hdr(2);
    for (int i = 0; i < 4; i++) exp_q.push_back(wd(2, 16'h0100 + i));
    push_hdr(0);
    exp_q.push_back(wd(0, 16'h0200));
    push_hdr(2);
    for (int i = 4; i < 6; i++) exp_q.push_back(wd(2, 16'h0100 + i));
    wait_done(1'b0, 200);
    check("trunc_once", 32'(trunc_cnt - tb_base), 32'd1);
    check("trunc_no_abort", 32'(abort_cnt - ab_base), 32'd0);
    check("trunc_acks2", 32'(ack_cnt[2] - a_base[2]), 32'd6);
    check("trunc_acks0", 32'(ack_cnt[0] - a_base[0]), 32'd1);

    // Requester 3 stalls after its first word; abort hands the link to requester 2.
    tb_base = trunc_cnt;
    ab_base = abort_cnt;
    src_push(3, wd(3, 16'h0300), 1'b0, 20);
    src_push(3, wd(3, 16'h0301), 1'b0, 0);
    src_push(3, wd(3, 16'h0302), 1'b1, 0);
    src_push(2, wd(2, 16'h0310), 1'b1, 0);
    push_hdr(3);
    exp_q.push_back(wd(3, 16'h0300));
    push_hdr(2);
    exp_q.push_back(wd(2, 16'h0310));
    push_hdr(3);
    exp_q.push_back(wd(3, 16'h0301));
    exp_q.push_back(wd(3, 16'h0302));
    wait_done(1'b0, 200);
    check("abort_once", 32'(abort_cnt - ab_base), 32'd1);
    check("abort_no_trunc", 32'(trunc_cnt - tb_base), 32'd0);

    // Reset while requester 1 sits in DATA.
    ab_base = abort_cnt;
    src_push(1, wd(1, 16'h0400), 1'b0, 50);
    src_push(1, wd(1, 16'h0401), 1'b0, 0);
    src_push(1, wd(1, 16'h0402), 1'b1, 0);
    push_hdr(1);
    exp_q.push_back(wd(1, 16'h0400));
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check("pre_rst_budget", 32'(n < 50), 32'd1);
    RST = 1'b0;
    tick();
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ack", 32'(req_ack), 32'd0);
    check("mid_rst_data", data_o, 32'h0);
    check("mid_rst_grant", 32'(grant_id), 32'd0);
    check("mid_rst_abort", 32'(abort_o), 32'd0);
    src_q[1].delete();
    hold[1] = 0;
    exp_q.delete();
    exp_seq = 0;
    tick();
    RST = 1'b1;
    tick();
    src_push(1, wd(1, 16'h0410), 1'b1, 0);
    push_hdr(1);
    exp_q.push_back(wd(1, 16'h0410));
    wait_done(1'b0, 100);
    check("rst_no_abort", 32'(abort_cnt - ab_base), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
